// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flash_arb_pkg
//  Purpose  : Shared types and constants for the DSPI flash reader arbiter.
//             Holds the arbiter state encoding and the flash address and
//             data widths.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package flash_arb_pkg;

  localparam int FLASH_AW = 22;
  localparam int FLASH_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HIT   = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/flash_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : flash_arb_rr
//  Purpose  : Combinational requester picker. Port 0 has fixed top priority.
//             Ports 1..NPORTS-1 are served round-robin, starting the scan at
//             rr_ptr and wrapping back to 1.
//  Ports    : req     [NPORTS] in   per-port request
//             rr_ptr  [IDXW]   in   first non-zero port to consider (1..N-1)
//             winner  [IDXW]   out  index of the selected port
//             valid   [1]      out  a port was selected
//  Revision : 1.0  initial release
// ============================================================================
module flash_arb_rr
  import flash_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int IDXW   = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDXW-1:0]   rr_ptr,
  output logic [IDXW-1:0]   winner,
  output logic              valid
);

  int              base;
  logic [IDXW-1:0] cand;

  // The scan runs from the farthest candidate down to the nearest one, so the
  // last match written is the port closest to rr_ptr.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    base   = (rr_ptr == '0) ? 0 : int'(rr_ptr) - 1;
    if (req[0]) begin
      valid = 1'b1;
    end else begin
      for (int k = NPORTS - 2; k >= 0; k--) begin
        cand = IDXW'(((base + k) % (NPORTS - 1)) + 1);
        if (req[cand]) begin
          valid  = 1'b1;
          winner = cand;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : flash_arbiter
//  Purpose  : Shares one DSPI flash reader between NPORTS requesters.
//             Sequences the reader's cs/busy handshake, gates grants on
//             flash_ready, and returns each 16-bit word with a one-cycle ack.
//             A one-entry last-word cache answers repeated reads of the same
//             address without touching the flash.
//  Ports    : clk          in   system clock (shared with the flash reader)
//             resetn       in   synchronous active-low reset
//             req   [N]    in   per-port request, held until ack
//             addr  [N*22] in   per-port word address, port i at [22i+21:22i]
//             rdata [16]   out  read data, valid while ack is high
//             ack   [N]    out  one-hot single-cycle completion pulse
//             flash_ready  in   reader init complete
//             flash_busy   in   reader transfer in progress
//             flash_dout   in   reader data word
//             flash_addr   out  address to the reader
//             flash_cs     out  start strobe (reader acts on its rising edge)
//  Revision : 1.0  initial release
// ============================================================================
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NPORTS        = 3,
  parameter int START_TIMEOUT = 8,
  parameter bit CACHE_EN      = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS*FLASH_AW-1:0] addr,
  output logic [FLASH_DW-1:0]      rdata,
  output logic [NPORTS-1:0]        ack,
  input  logic                     flash_ready,
  input  logic                     flash_busy,
  input  logic [FLASH_DW-1:0]      flash_dout,
  output logic [FLASH_AW-1:0]      flash_addr,
  output logic                     flash_cs
);

  localparam int IDXW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TW   = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;

  arb_state_t          state;
  logic [IDXW-1:0]     win_idx;
  logic [IDXW-1:0]     rr_ptr;
  logic [TW-1:0]       tcnt;
  logic                gap_cnt;
  logic                cache_valid;
  logic [FLASH_AW-1:0] cache_addr;
  logic [FLASH_DW-1:0] cache_data;

  logic [IDXW-1:0]     pick_idx;
  logic                pick_valid;
  logic [FLASH_AW-1:0] pick_addr;
  logic [NPORTS-1:0]   win_onehot;
  logic                cache_hit;

  logic [FLASH_AW-1:0] port_addr [NPORTS];

  generate
    for (genvar i = 0; i < NPORTS; i++) begin : g_port_addr
      assign port_addr[i] = addr[FLASH_AW*i +: FLASH_AW];
    end
  endgenerate

  flash_arb_rr #(
    .NPORTS (NPORTS),
    .IDXW   (IDXW)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_addr  = port_addr[pick_idx];
  assign win_onehot = NPORTS'(1) << win_idx;
  assign cache_hit  = CACHE_EN && cache_valid && (cache_addr == pick_addr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ack         <= '0;
      rdata       <= '0;
      flash_cs    <= 1'b0;
      flash_addr  <= '0;
      win_idx     <= '0;
      rr_ptr      <= IDXW'(1);
      tcnt        <= '0;
      gap_cnt     <= 1'b0;
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          if (flash_ready && pick_valid) begin
            win_idx <= pick_idx;
            if (cache_hit) begin
              state <= ST_HIT;
            end else begin
              flash_addr <= pick_addr;
              flash_cs   <= 1'b1;
              tcnt       <= '0;
              gap_cnt    <= 1'b0;
              state      <= ST_START;
            end
          end
        end

        // busy is honoured even during a retry gap: a late response to the
        // previous strobe still means the reader has started this address.
        ST_START: begin
          if (flash_busy) begin
            flash_cs <= 1'b0;
            state    <= ST_WAIT;
          end else if (flash_cs) begin
            if (tcnt == TW'(START_TIMEOUT - 1)) begin
              flash_cs <= 1'b0;
              gap_cnt  <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else begin
            // Two low cycles give the reader's synchroniser a clean edge.
            if (gap_cnt) begin
              flash_cs <= 1'b1;
              tcnt     <= '0;
            end else begin
              gap_cnt <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (!flash_busy) begin
            rdata       <= flash_dout;
            cache_data  <= flash_dout;
            cache_addr  <= flash_addr;
            cache_valid <= 1'b1;
            ack         <= win_onehot;
            state       <= ST_DONE;
          end
        end

        ST_HIT: begin
          rdata <= cache_data;
          ack   <= win_onehot;
          state <= ST_DONE;
        end

        // ack is high during this state; req is deliberately not looked at.
        ST_DONE: begin
          ack <= '0;
          if (win_idx != '0) begin
            rr_ptr <= (win_idx == IDXW'(NPORTS - 1)) ? IDXW'(1) : win_idx + 1'b1;
          end
          state <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          ack      <= '0;
          flash_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_arbiter
//  Purpose  : Directed self-checking bench for flash_arbiter. Instance a has
//             the cache enabled, instance b has it disabled. Each has its own
//             behavioural flash reader: 2-stage cs sync, busy for 33 cycles,
//             dout = addr[15:0] ^ 16'hA5A5.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ready;
  logic [2:0]  req_a, req_b;
  logic [65:0] addr_a, addr_b;
  logic [15:0] rdata_a, rdata_b;
  logic [2:0]  ack_a, ack_b;
  logic [21:0] fa_a, fa_b;
  logic        cs_a, cs_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural flash reader models, index 0 -> instance a, 1 -> instance b.
  logic [1:0]  m_s1 = '0, m_s2 = '0, m_busy = '0, withhold = '0;
  int          m_cnt [2] = '{0, 0};
  logic [15:0] m_dout [2];
  wire  [1:0]  m_cs = {cs_b, cs_a};

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      m_s1[m] <= m_cs[m];
      m_s2[m] <= m_s1[m];
      if (m_busy[m]) begin
        if (m_cnt[m] == 1) m_busy[m] <= 1'b0;
        m_cnt[m] <= m_cnt[m] - 1;
      end else if (m_s1[m] && !m_s2[m] && !withhold[m]) begin
        m_busy[m] <= 1'b1;
        m_cnt[m]  <= 33;
        m_dout[m] <= ((m == 0) ? fa_a[15:0] : fa_b[15:0]) ^ 16'hA5A5;
      end
    end
  end

  // Rising edges of each cs, used to tell cache hits from flash reads.
  logic cs_a_d = 1'b0, cs_b_d = 1'b0;
  int   rise_a = 0, rise_b = 0;
  always @(posedge clk) begin
    cs_a_d <= cs_a;
    cs_b_d <= cs_b;
    if (cs_a && !cs_a_d) rise_a <= rise_a + 1;
    if (cs_b && !cs_b_d) rise_b <= rise_b + 1;
  end

  flash_arbiter #(.NPORTS(3), .START_TIMEOUT(8), .CACHE_EN(1'b1)) dut_a (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req_a),
    .addr        (addr_a),
    .rdata       (rdata_a),
    .ack         (ack_a),
    .flash_ready (ready),
    .flash_busy  (m_busy[0]),
    .flash_dout  (m_dout[0]),
    .flash_addr  (fa_a),
    .flash_cs    (cs_a)
  );

  flash_arbiter #(.NPORTS(3), .START_TIMEOUT(8), .CACHE_EN(1'b0)) dut_b (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req_b),
    .addr        (addr_b),
    .rdata       (rdata_b),
    .ack         (ack_b),
    .flash_ready (ready),
    .flash_busy  (m_busy[1]),
    .flash_dout  (m_dout[1]),
    .flash_addr  (fa_b),
    .flash_cs    (cs_b)
  );

  // Waits up to 'limit' negedges for any ack; seen stays 0 on expiry.
  task automatic wait_ack(input bit sel, input int limit,
                          output logic [2:0] seen, output int cycles);
    seen   = '0;
    cycles = 0;
    while (seen == 3'b000 && cycles < limit) begin
      @(negedge clk);
      cycles++;
      seen = sel ? ack_b : ack_a;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; ready = 1'b0;
    req_a = '0; req_b = '0; addr_a = '0; addr_b = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (ack_a !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b want 000", ack_a); end
    n_checks++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", rdata_a); end
    n_checks++; if (cs_a !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", cs_a); end
    n_checks++; if (fa_a !== 22'h0) begin n_fail++; $display("FAIL reset_faddr: got %h want 0", fa_a); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ready_gate;
    int bad; logic [2:0] seen; int cyc;
    req_a = 3'b001; addr_a[21:0] = 22'h000123;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs_a !== 1'b0 || ack_a !== 3'b000) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ready_gate: got %0d active cycles want 0", bad); end
    ready = 1'b1;
    @(negedge clk);
    n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL ready_cs_rise: got %b want 1", cs_a); end
    wait_ack(1'b0, 100, seen, cyc);
    n_checks++; if (seen !== 3'b001) begin n_fail++; $display("FAIL ready_ack: got %b want 001", seen); end
    n_checks++; if (rdata_a !== 16'hA486) begin n_fail++; $display("FAIL ready_rdata: got %h want a486", rdata_a); end
    req_a = '0;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_seq [4]; logic [2:0] seen; int cyc; logic [15:0] want;
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b010; exp_seq[3] = 3'b100;
    addr_a[43:22] = 22'h000010; addr_a[65:44] = 22'h000020;
    req_a = 3'b110;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, 150, seen, cyc);
      want = (exp_seq[i] == 3'b010) ? 16'hA5B5 : 16'hA585;
      n_checks++; if (seen !== exp_seq[i]) begin n_fail++; $display("FAIL rr_ack%0d: got %b want %b", i, seen, exp_seq[i]); end
      n_checks++; if (rdata_a !== want) begin n_fail++; $display("FAIL rr_rdata%0d: got %h want %h", i, rdata_a, want); end
    end
    req_a = '0;
  endtask

  task automatic test_priority;
    logic [2:0] seen; int cyc;
    addr_a[21:0] = 22'h000123;
    req_a = 3'b011;
    for (int i = 0; i < 6; i++) begin
      wait_ack(1'b0, 100, seen, cyc);
      n_checks++; if (seen !== 3'b001) begin n_fail++; $display("FAIL prio_ack%0d: got %b want 001", i, seen); end
    end
    req_a = 3'b010;
    wait_ack(1'b0, 100, seen, cyc);
    n_checks++; if (seen !== 3'b010) begin n_fail++; $display("FAIL prio_release: got %b want 010", seen); end
    n_checks++; if (rdata_a !== 16'hA5B5) begin n_fail++; $display("FAIL prio_rdata: got %h want a5b5", rdata_a); end
    req_a = '0;
  endtask

  task automatic test_back_to_back;
    logic [2:0] seen; int cyc; int r0;
    addr_a[43:22] = 22'h3FFFFF;
    req_a = 3'b010;
    wait_ack(1'b0, 100, seen, cyc);
    n_checks++; if (seen !== 3'b010) begin n_fail++; $display("FAIL b2b_first_ack: got %b want 010", seen); end
    n_checks++; if (rdata_a !== 16'h5A5A) begin n_fail++; $display("FAIL b2b_first_rdata: got %h want 5a5a", rdata_a); end
    req_a = '0;
    @(negedge clk);
    r0 = rise_a;
    req_a = 3'b010;
    wait_ack(1'b0, 100, seen, cyc);
    n_checks++; if (cyc != 2 || seen !== 3'b010) begin n_fail++; $display("FAIL hit_latency: got %0d cycles ack %b want 2 cycles ack 010", cyc, seen); end
    n_checks++; if (rdata_a !== 16'h5A5A) begin n_fail++; $display("FAIL hit_rdata: got %h want 5a5a", rdata_a); end
    n_checks++; if (rise_a != r0) begin n_fail++; $display("FAIL hit_no_cs: got %0d cs edges want 0", rise_a - r0); end
    req_a = '0;
    // Same sequence on the cache-less instance: the repeat goes to flash.
    addr_b[43:22] = 22'h3FFFFF;
    req_b = 3'b010;
    wait_ack(1'b1, 100, seen, cyc);
    n_checks++; if (seen !== 3'b010) begin n_fail++; $display("FAIL nocache_first_ack: got %b want 010", seen); end
    req_b = '0;
    @(negedge clk);
    r0 = rise_b;
    req_b = 3'b010;
    wait_ack(1'b1, 100, seen, cyc);
    n_checks++; if (cyc != 37 || seen !== 3'b010) begin n_fail++; $display("FAIL nocache_latency: got %0d cycles ack %b want 37 cycles ack 010", cyc, seen); end
    n_checks++; if (rise_b != r0 + 1) begin n_fail++; $display("FAIL nocache_cs: got %0d cs edges want 1", rise_b - r0); end
    n_checks++; if (rdata_b !== 16'h5A5A) begin n_fail++; $display("FAIL nocache_rdata: got %h want 5a5a", rdata_b); end
    req_b = '0;
  endtask

  task automatic test_timeout;
    logic [2:0] seen; int cyc; int t; int hi; int lo;
    withhold = 2'b01;
    addr_a[43:22] = 22'h0002A5;
    req_a = 3'b010;
    t = 0;
    while (cs_a !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL to_cs_start: got %b want 1", cs_a); end
    hi = 0;
    while (cs_a === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
    n_checks++; if (hi != 8) begin n_fail++; $display("FAIL to_cs_high: got %0d cycles want 8", hi); end
    lo = 0;
    while (cs_a === 1'b0 && lo < 40) begin lo++; @(negedge clk); end
    n_checks++; if (lo != 2) begin n_fail++; $display("FAIL to_cs_gap: got %0d cycles want 2", lo); end
    withhold = 2'b00;
    wait_ack(1'b0, 100, seen, cyc);
    n_checks++; if (seen !== 3'b010) begin n_fail++; $display("FAIL to_ack: got %b want 010", seen); end
    n_checks++; if (rdata_a !== 16'hA700) begin n_fail++; $display("FAIL to_rdata: got %h want a700", rdata_a); end
    req_a = '0;
  endtask

  task automatic test_reset_mid;
    logic [2:0] seen; int cyc; int t; int acks; int r0;
    addr_a[65:44] = 22'h000155;
    req_a = 3'b100;
    t = 0;
    while (!(m_busy[0] === 1'b1 && cs_a === 1'b0) && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (m_busy[0] !== 1'b1 || cs_a !== 1'b0) begin n_fail++; $display("FAIL rst_reach_wait: got busy %b cs %b want busy 1 cs 0", m_busy[0], cs_a); end
    repeat (5) @(negedge clk);
    resetn = 1'b0; req_a = '0;
    @(negedge clk);
    resetn = 1'b1;
    n_checks++; if (cs_a !== 1'b0 || fa_a !== 22'h0 || rdata_a !== 16'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got cs %b addr %h rdata %h want 0 0 0", cs_a, fa_a, rdata_a); end
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_a !== 3'b000) acks++;
    end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rst_no_ack: got %0d ack cycles want 0", acks); end
    // 0x2A5 was cached before the reset; it must now come from flash.
    r0 = rise_a;
    req_a = 3'b010;
    wait_ack(1'b0, 100, seen, cyc);
    n_checks++; if (cyc != 37 || seen !== 3'b010) begin n_fail++; $display("FAIL rst_miss_latency: got %0d cycles ack %b want 37 cycles ack 010", cyc, seen); end
    n_checks++; if (rise_a != r0 + 1) begin n_fail++; $display("FAIL rst_cache_invalid: got %0d cs edges want 1", rise_a - r0); end
    n_checks++; if (rdata_a !== 16'hA700) begin n_fail++; $display("FAIL rst_rdata: got %h want a700", rdata_a); end
    req_a = '0;
  endtask

  initial begin
    test_reset();
    test_ready_gate();
    test_round_robin();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
